demux1_3_buf: RTL and testbench

//  1-to-3 routing demultiplexer with a 2-entry FIFO on each output. This is the

---
 rtl/demux1_3_buf_if.sv | 64 ++++++
 rtl/demux1_3_buf.sv | 113 +++++++++++
 tb/tb_demux1_3_buf.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/demux1_3_buf_if.sv
// ---------------------------------------------------------------------------
// demux1_3_buf_if
//   Bundles the producer stream and the three consumer streams of the 1:3
//   buffered demultiplexer.
//
//   Handshake semantics (all streams): a word moves at a rising clk edge when
//   valid and ready are both high at that edge. Ready never depends
//   combinationally on the valid of the same stream. Once valid is raised,
//   the sender holds data (and in_sel) stable until the transfer happens.
//
//   Signals
//     in_valid   producer has a word
//     in_ready   word at in_data/in_sel accepted this edge if in_valid
//     in_data    producer payload
//     in_sel     destination: 00->0, 01->1, 10/11->2
//     out_valid  bit k: out_data<k> holds a valid word
//     out_ready  bit k: consumer k takes the word this edge
//     out_data0/1/2  head word of FIFO 0/1/2
//     out_cnt    {cnt2,cnt1,cnt0}, 2-bit occupancy per FIFO
//
//   Modports
//     master  producer/consumer side (drives in_*, out_ready)
//     slave   the demux itself
// ---------------------------------------------------------------------------
interface demux1_3_buf_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [5:0]        out_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_sel,
        input  out_valid,
        output out_ready,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_sel,
        output out_valid,
        input  out_ready,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_cnt
    );
endinterface

// File: rtl/demux1_3_buf.sv
// ---------------------------------------------------------------------------
// demux1_3_buf
//   1-to-3 routing demultiplexer. One valid/ready producer stream is steered
//   by in_sel to one of three consumers, each behind its own 2-entry FIFO so
//   that a stalled consumer never blocks the other two.
//
//   Ports
//     clk    clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset; empties every FIFO and zeroes
//            storage, pointers and counts
//     bus    demux1_3_buf_if.slave (producer stream in, three consumer
//            streams out, per-FIFO occupancy)
//
//   Timing
//     A word accepted at edge N is visible on its output from N+1; there is
//     no bypass path. in_ready depends only on in_sel, rst_n and the
//     registered counts, so there is no combinational path from any
//     out_ready to in_ready. A full destination refuses a push even when it
//     pops in the same cycle.
// ---------------------------------------------------------------------------
module demux1_3_buf #(
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    demux1_3_buf_if.slave  bus
);

    // Per-FIFO storage and bookkeeping; the outer index is the destination.
    logic [DATA_W-1:0] mem_q [3][2];
    logic [DATA_W-1:0] mem_d [3][2];
    logic [2:0]        rd_ptr_q;
    logic [2:0]        rd_ptr_d;
    logic [2:0]        wr_ptr_q;
    logic [2:0]        wr_ptr_d;
    logic [1:0]        cnt_q [3];
    logic [1:0]        cnt_d [3];

    logic [2:0] dest_oh;   // one-hot decode of in_sel
    logic [2:0] full;
    logic [2:0] valid;
    logic [2:0] push;
    logic [2:0] pop;
    logic       dest_full;

    // 2'b11 aliases onto destination 2.
    always_comb begin
        dest_oh = 3'b000;
        case (bus.in_sel)
            2'b00:   dest_oh = 3'b001;
            2'b01:   dest_oh = 3'b010;
            default: dest_oh = 3'b100;
        endcase
    end

    always_comb begin
        full  = 3'b000;
        valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            full[k]  = (cnt_q[k] == 2'd2);
            valid[k] = (cnt_q[k] != 2'd0);
        end
    end

    assign dest_full    = |(dest_oh & full);
    assign bus.in_ready = rst_n & ~dest_full;

    assign push = {3{bus.in_valid & bus.in_ready}} & dest_oh;
    // out_ready on an empty FIFO is simply ignored.
    assign pop  = valid & bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 3; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = bus.in_data;
            end
            // 1-bit pointers wrap 1->0 by toggling.
            wr_ptr_d[k] = wr_ptr_q[k] ^ push[k];
            rd_ptr_d[k] = rd_ptr_q[k] ^ pop[k];
            cnt_d[k]    = cnt_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                cnt_q[k]    <= 2'd0;
            end
            rd_ptr_q <= 3'b000;
            wr_ptr_q <= 3'b000;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Heads are driven straight from storage, so they hold steady while a
    // consumer stalls.
    assign bus.out_valid = valid;
    assign bus.out_data0 = mem_q[0][rd_ptr_q[0]];
    assign bus.out_data1 = mem_q[1][rd_ptr_q[1]];
    assign bus.out_data2 = mem_q[2][rd_ptr_q[2]];
    assign bus.out_cnt   = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_demux1_3_buf.sv
module tb_demux1_3_buf;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    demux1_3_buf_if #(.DATA_W(DW)) bus ();

    demux1_3_buf #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q [3][$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of(input logic [1:0] sel);
        return (sel == 2'b00) ? 0 : (sel == 2'b01) ? 1 : 2;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model at the
    // falling edge, then update the model for what happens at the next edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic [DW-1:0] d,
                        input logic [2:0] rdy, output logic acc, output logic obs_rdy);
        int            dst;
        logic [2:0]    ev;
        logic [5:0]    ecnt;
        logic          erdy;
        logic [DW-1:0] head;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(negedge clk);
        dst = dest_of(sel);
        for (int k = 0; k < 3; k++) begin
            ev[k]            = (exp_q[k].size() != 0);
            ecnt[2*k +: 2]   = 2'(exp_q[k].size());
        end
        erdy    = (exp_q[dst].size() != 2);
        obs_rdy = bus.in_ready;
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        chk("out_cnt", 64'(bus.out_cnt), 64'(ecnt));
        chk("in_ready", 64'(bus.in_ready), 64'(erdy));
        for (int k = 0; k < 3; k++) begin
            if (ev[k]) begin
                head = (k == 0) ? bus.out_data0 : (k == 1) ? bus.out_data1 : bus.out_data2;
                chk($sformatf("out_data%0d", k), 64'(head), 64'(exp_q[k][0]));
                if (rdy[k]) void'(exp_q[k].pop_front());
            end
        end
        acc = v && erdy;
        if (acc) exp_q[dst].push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;       // offered word must be ignored under reset
        bus.in_sel    = 2'b00;
        bus.in_data   = 32'h0BAD_0BAD;
        bus.out_ready = 3'b000;
        repeat (cycles) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
        chk("rst_out_data0", 64'(bus.out_data0), 64'd0);
        chk("rst_out_data1", 64'(bus.out_data1), 64'd0);
        chk("rst_out_data2", 64'(bus.out_data2), 64'd0);
    endtask

    task automatic drain(input int n);
        logic a, r;
        repeat (n) step(1'b0, 2'b00, '0, 3'b111, a, r);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic          acc, rdy;
        logic          hv;
        logic [1:0]    hsel;
        logic [DW-1:0] hdata;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 3'b000;
        do_reset(2);

        // 1: single word, one-cycle latency, then gone
        step(1'b1, 2'b00, 32'hA5A5_0001, 3'b111, acc, rdy);
        chk("t1_valid_next", 64'(bus.out_valid), 64'b001);
        chk("t1_data_next", 64'(bus.out_data0), 64'hA5A5_0001);
        step(1'b0, 2'b00, '0, 3'b111, acc, rdy);
        chk("t1_valid_gone", 64'(bus.out_valid), 64'b000);

        // 2: fill FIFO 1, third word refused, other destination still open
        step(1'b1, 2'b01, 32'h1111_0001, 3'b000, acc, rdy);
        step(1'b1, 2'b01, 32'h1111_0002, 3'b000, acc, rdy);
        chk("t2_cnt1_full", 64'(bus.out_cnt[3:2]), 64'd2);
        step(1'b1, 2'b01, 32'h1111_0003, 3'b000, acc, rdy);
        chk("t2_third_refused", 64'(rdy), 64'd0);
        step(1'b0, 2'b00, 32'h0000_0000, 3'b000, acc, rdy);
        chk("t2_sel0_ready", 64'(rdy), 64'd1);
        drain(3);

        // 3: full FIFO 2, pop and refused push in the same cycle
        step(1'b1, 2'b10, 32'h2222_0001, 3'b000, acc, rdy);
        step(1'b1, 2'b10, 32'h2222_0002, 3'b000, acc, rdy);
        step(1'b1, 2'b10, 32'h2222_0003, 3'b100, acc, rdy);
        chk("t3_full_refused", 64'(rdy), 64'd0);
        chk("t3_cnt2_after_pop", 64'(bus.out_cnt[5:4]), 64'd1);
        step(1'b1, 2'b10, 32'h2222_0003, 3'b000, acc, rdy);
        chk("t3_retry_accepted", 64'(rdy), 64'd1);
        chk("t3_head_order", 64'(bus.out_data2), 64'h2222_0002);
        drain(3);

        // 4: sel=11 aliases onto FIFO 2
        step(1'b1, 2'b11, 32'hDEAD_BEEF, 3'b000, acc, rdy);
        chk("t4_alias_valid", 64'(bus.out_valid), 64'b100);
        chk("t4_alias_data", 64'(bus.out_data2), 64'hDEAD_BEEF);
        drain(2);

        // 5: random traffic, producer holds an offered word until accepted
        hv    = 1'b0;
        hsel  = 2'b00;
        hdata = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!hv) begin
                hv    = ($urandom_range(0, 3) != 0);
                hsel  = 2'($urandom_range(0, 3));
                hdata = $urandom;
            end
            step(hv, hsel, hdata, 3'($urandom_range(0, 7)), acc, rdy);
            if (acc) hv = 1'b0;
        end
        drain(3);

        // 6: reset with every FIFO full, stale words must never reappear
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'(k), 32'h5A1E_0000 + 32'(2*k),     3'b000, acc, rdy);
            step(1'b1, 2'(k), 32'h5A1E_0000 + 32'(2*k + 1), 3'b000, acc, rdy);
        end
        chk("t6_all_full", 64'(bus.out_cnt), 64'b10_10_10);
        do_reset(1);
        step(1'b1, 2'b00, 32'hF00D_0000, 3'b000, acc, rdy);
        step(1'b1, 2'b01, 32'hF00D_0001, 3'b000, acc, rdy);
        step(1'b1, 2'b10, 32'hF00D_0002, 3'b000, acc, rdy);
        chk("t6_fresh_cnt", 64'(bus.out_cnt), 64'b01_01_01);
        drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
